seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
// Handles signed (truncating) and unsigned division, with single-cycle fast
// paths for divide-by-zero and signed most-negative / -1 overflow.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef struct packed {
        logic             sm;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;     // partial remainder
    logic [WIDTH-1:0] dq;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;     // divisor magnitude
    logic             sign_q, sign_r;

    req_t             req;
    logic             a_neg, b_neg, dz_c, ovf_c;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] shifted, trial;

    assign req   = '{sm: signed_mode, a: dividend, b: divisor};
    assign a_neg = req.sm & req.a[WIDTH-1];
    assign b_neg = req.sm & req.b[WIDTH-1];
    assign a_mag = a_neg ? -req.a : req.a;
    assign b_mag = b_neg ? -req.b : req.b;
    assign dz_c  = (req.b == '0);
    assign ovf_c = req.sm && (req.a == MIN_NEG) && (req.b == '1);

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    assign shifted = {rem, dq[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs};

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (dz_c || ovf_c) ? DONE : CALC;
            CALC: if (cnt == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            dq          <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (dz_c) begin
                        quotient    <= '1;
                        remainder   <= req.a;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (ovf_c) begin
                        quotient    <= req.a;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else begin
                        rem    <= '0;
                        dq     <= a_mag;
                        dvs    <= b_mag;
                        cnt    <= '0;
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        rem <= trial[WIDTH:0];
                        dq  <= {dq[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH:0];
                        dq  <= {dq[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient    <= sign_q ? -dq : dq;
                    remainder   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, hand-written corner
// sequences (ignored restart, mid-operation reset) and random operations
// checked against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           sm;
        logic [W-1:0] a, b, q, r;
        bit           dz, ov;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output bit dz, output bit ov, output int lat);
        longint sa, sb;
        dz = 0; ov = 0; lat = W + 2;
        if (b == 0) begin
            q = '1; r = a; dz = 1; lat = 1;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0; ov = 1; lat = 1;
        end else if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Pulse start for one accept edge; returns #1 after the accept edge
    task automatic launch(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; signed_mode = $urandom;
    endtask

    // Poll for done with a cycle budget; lat counts edges from the accept edge
    task automatic wait_done(output int lat, output int bcnt, output bit ovl);
        lat = 0; bcnt = 0; ovl = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) bcnt++;
            if (busy && done) ovl = 1;
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string nm, input bit sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input bit edz, input bit eov,
                          input int elat);
        int lat, bcnt;
        bit ovl;
        launch(sm, a, b);
        wait_done(lat, bcnt, ovl);
        chk({nm, ".latency"}, lat, elat);
        chk({nm, ".busy_cycles"}, bcnt, (elat == 1) ? 0 : elat - 1);
        chk({nm, ".busy_done_overlap"}, ovl, 0);
        chk({nm, ".quotient"}, quotient, eq);
        chk({nm, ".remainder"}, remainder, er);
        chk({nm, ".div_by_zero"}, div_by_zero, edz);
        chk({nm, ".overflow"}, overflow, eov);
        @(posedge clk); #1;
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".hold"}, {quotient, remainder}, {eq, er});
    endtask

    vec_t tbl[11];

    initial begin
        logic [W-1:0] q, r, a, b;
        bit dz, ov, sm;
        int lat, bcnt;
        bit ovl;

        tbl[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 0, 34};
        tbl[1]  = '{1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  0, 0, 34};
        tbl[2]  = '{1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          0, 0, 34};
        tbl[3]  = '{0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1, 0, 1};
        tbl[4]  = '{1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1, 0, 1};
        tbl[5]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 1, 1};
        tbl[6]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0, 0, 34};
        tbl[7]  = '{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0, 0, 34};
        tbl[8]  = '{0, 32'd5,          32'd9,          32'd0,          32'd5,          0, 0, 34};
        tbl[9]  = '{1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 1};
        tbl[10] = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  0, 0, 34};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {busy, done, div_by_zero, overflow, quotient, remainder}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.idle", {busy, done}, 2'b00);

        // Directed vectors
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), tbl[i].sm, tbl[i].a, tbl[i].b,
                   tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, tbl[i].lat);

        // start re-pulsed with new operands during CALC is ignored
        launch(0, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd7; divisor = 32'd2;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt, ovl);
        chk("restart.seen_done", lat != 0, 1);
        chk("restart.result", {quotient, remainder}, {32'd333, 32'd1});
        @(posedge clk); #1;
        chk("restart.no_requeue", {busy, done}, 2'b00);

        // Reset mid-CALC clears everything at once
        launch(0, 32'd500, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.outputs", {busy, done, div_by_zero, overflow, quotient, remainder}, '0);
        @(posedge clk); #1;
        chk("midreset.held", {busy, done, quotient}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 0, 32'd500, 32'd7, 32'd71, 32'd3, 0, 0, 34);

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            sm = $urandom;
            a  = $urandom;
            case ($urandom % 5)
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = ($urandom % 2) ? 32'hFFFF_FFFF : 32'd0;
                3: b = $urandom >> ($urandom % 32);
                default: b = -($urandom_range(1, 20));
            endcase
            if ($urandom % 6 == 0) a = 32'h8000_0000;
            model(sm, a, b, q, r, dz, ov, lat);
            run_op($sformatf("rnd%0d", n), sm, a, b, q, r, dz, ov, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
